washer_plant: RTL

WASHER_PLANT -- requirements
Module: washer_plant

---
 rtl/washer_pkg.sv | 39 +++
 rtl/washer_tick_gen.sv | 22 ++
 rtl/washer_plant.sv | 123 ++++++++++++
 3 files changed

// File: rtl/washer_pkg.sv
// Shared types and default parameters for the washing-machine plant model.
package washer_pkg;

   localparam int unsigned PRESCALE_DEF  = 5000000;
   localparam int unsigned LEVEL_MAX_DEF = 20;
   localparam int unsigned AGIT_TIME_DEF = 30;
   localparam int unsigned CENT_TIME_DEF = 50;

   typedef enum logic [2:0] {
      PARADO,
      ENCHENDO,
      LAVANDO,
      CENTRIFUGANDO,
      ESVAZIANDO,
      FALHA
   } plant_state_t;

   typedef struct packed {
      logic bomba;
      logic agitar;
      logic girar;
      logic centrifugar;
   } cmd_t;

   // One-hot LED view; PARADO and ESVAZIANDO have no LED of their own.
   function automatic logic [3:0] state_leds(input plant_state_t s);
      logic [3:0] leds;
      leds = 4'b0000;
      case (s)
         ENCHENDO:      leds = 4'b0001;
         LAVANDO:       leds = 4'b0010;
         CENTRIFUGANDO: leds = 4'b0100;
         FALHA:         leds = 4'b1000;
         default:       leds = 4'b0000;
      endcase
      return leds;
   endfunction

endpackage

// File: rtl/washer_tick_gen.sv
// Free-running prescaler producing a one-cycle plant tick every PRESCALE clocks.
module washer_tick_gen #(
   parameter int unsigned PRESCALE = washer_pkg::PRESCALE_DEF
) (
   input  logic clk,
   input  logic clr,
   output logic tick_c
);

   localparam int unsigned CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] cnt_q;

   assign tick_c = (cnt_q == CNT_LAST);

   always_ff @(posedge clk) begin
      if (clr || tick_c) cnt_q <= '0;
      else               cnt_q <= cnt_q + CNT_W'(1);
   end

endmodule

// File: rtl/washer_plant.sv
// Washing-machine plant model: water level, motor-phase timer and fault
// detection driven by the controller's pump and motor-mode commands.
module washer_plant #(
   parameter int unsigned PRESCALE  = washer_pkg::PRESCALE_DEF,
   parameter int unsigned LEVEL_MAX = washer_pkg::LEVEL_MAX_DEF,
   parameter int unsigned AGIT_TIME = washer_pkg::AGIT_TIME_DEF,
   parameter int unsigned CENT_TIME = washer_pkg::CENT_TIME_DEF
) (
   input  logic       CLOCK_50,
   input  logic [2:0] KEY,
   input  logic       bomba_agua,
   input  logic       modo_agitar,
   input  logic       modo_girar,
   input  logic       modo_centrifugar,
   output logic [7:0] nivel,
   output logic       nivel_cheio,
   output logic       nivel_vazio,
   output logic       tempo_ok,
   output logic       erro,
   output logic [3:0] LEDG
);
   import washer_pkg::*;

   localparam int unsigned TIME_MAX = (AGIT_TIME > CENT_TIME) ? AGIT_TIME : CENT_TIME;
   localparam int unsigned TMR_W    = $clog2(TIME_MAX + 1);
   localparam logic [7:0]       LVL_MAX  = 8'(LEVEL_MAX);
   localparam logic [TMR_W-1:0] AGIT_LIM = TMR_W'(AGIT_TIME);
   localparam logic [TMR_W-1:0] CENT_LIM = TMR_W'(CENT_TIME);

   logic rst;
   logic unused_keys;
   assign rst         = KEY[2];
   assign unused_keys = ^KEY[1:0];

   cmd_t             cmd_q, cmd_prev;
   plant_state_t     state_q, state_d;
   logic [7:0]       nivel_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [TMR_W-1:0] limit_c;
   logic             tick_c, cmd_chg_c, phase_c, tempo_ok_d;

   washer_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
      .clk    (CLOCK_50),
      .clr    (rst),
      .tick_c (tick_c)
   );

   // Command register plus one-cycle history for change detection.
   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         cmd_q    <= '0;
         cmd_prev <= '0;
      end else begin
         cmd_q.bomba       <= bomba_agua;
         cmd_q.agitar      <= modo_agitar;
         cmd_q.girar       <= modo_girar;
         cmd_q.centrifugar <= modo_centrifugar;
         cmd_prev          <= cmd_q;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (rst) state_q <= PARADO;
      else     state_q <= state_d;
   end

   // Decode, level and timer update all act on the freshly decoded state.
   always_comb begin
      state_d    = state_q;
      nivel_d    = nivel;
      timer_d    = timer_q;
      tempo_ok_d = 1'b0;
      cmd_chg_c  = (cmd_q != cmd_prev);

      if (state_q != FALHA) begin
         case (cmd_q)
            4'b0000: state_d = (nivel != 8'd0) ? ESVAZIANDO : PARADO;
            4'b1000: state_d = ENCHENDO;
            4'b0100,
            4'b0010: state_d = (nivel == 8'd0) ? FALHA : LAVANDO;
            4'b0001: state_d = (state_q != CENTRIFUGANDO && nivel != 8'd0) ? FALHA
                                                                          : CENTRIFUGANDO;
            default: state_d = FALHA;
         endcase
      end

      phase_c = (state_d == LAVANDO) || (state_d == CENTRIFUGANDO);
      limit_c = (state_d == CENTRIFUGANDO) ? CENT_LIM : AGIT_LIM;

      if (tick_c) begin
         if (state_d == ENCHENDO && nivel < LVL_MAX)    nivel_d = nivel + 8'd1;
         if (state_d == ESVAZIANDO && nivel != 8'd0)    nivel_d = nivel - 8'd1;
      end

      if (state_d != FALHA) begin
         if (cmd_chg_c) timer_d = '0;
         if (phase_c && tick_c && timer_d < limit_c) timer_d = timer_d + TMR_W'(1);
         // Stale timer value belongs to the previous command; suppress on change.
         tempo_ok_d = phase_c && !cmd_chg_c && (timer_q >= limit_c);
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         nivel       <= 8'd0;
         timer_q     <= '0;
         nivel_cheio <= 1'b0;
         nivel_vazio <= 1'b1;
         tempo_ok    <= 1'b0;
         erro        <= 1'b0;
         LEDG        <= 4'b0000;
      end else begin
         nivel       <= nivel_d;
         timer_q     <= timer_d;
         nivel_cheio <= (nivel_d == LVL_MAX);
         nivel_vazio <= (nivel_d == 8'd0);
         tempo_ok    <= tempo_ok_d;
         erro        <= (state_d == FALHA);
         LEDG        <= state_leds(state_d);
      end
   end

endmodule
